mips_mult_ctrl: RTL and testbench

//  Iterative shift-add multiply sequencer owning the HI/LO register pair for MULT/MULTU/MFHI/MFLO/MTHI/MTLO.

---
 rtl/mips_mult_ctrl.sv | 95 +++++++++
 tb/tb_mips_mult_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mips_mult_ctrl.sv
// Iterative radix-2 shift-add multiply sequencer holding the MIPS HI/LO pair.
// Signed products use magnitude multiply followed by a final 2*WIDTH negate.
module mips_mult_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mult;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] product;

  // Negating 0x8000_0000 yields 0x8000_0000, which is the correct unsigned magnitude.
  always_comb begin
    a_mag    = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    b_mag    = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mult[0] ? {1'b0, mcand} : '0);
    product  = neg ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      mult  <= '0;
      acc   <= '0;
      count <= '0;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a_mag;
            mult  <= b_mag;
            neg   <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        RUN: begin
          // Carry out of the upper-half add becomes the new MSB after the shift.
          acc   <= {step_sum, acc[WIDTH-1:1]};
          mult  <= mult >> 1;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIN;
        end
        FIN: begin
          {hi, lo} <= product;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mult_ctrl.sv
// Directed bench for mips_mult_ctrl: product table plus hand-written busy/reset/write sequences.
module tb_mips_mult_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int tests = 0;
  int fails = 0;

  mips_mult_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge after the start edge.
  task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic hw, input logic lw, input logic [W-1:0] wd);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    hi_we = hw; lo_we = lw; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op_a = $urandom; op_b = $urandom; is_signed = ~s;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  // Returns at the falling edge where done is seen, or after a bounded timeout.
  task automatic wait_done(input string name, input int exp_lat);
    int lat;
    logic busy_bad;
    lat = 0;
    busy_bad = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      lat = i;
      if (done) break;
      if (busy !== 1'b1) busy_bad = 1'b1;
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy_run"}, {63'd0, busy_bad}, 64'd0);
    check({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic count_stray_done(input string name, input int cycles, input int exp_cnt);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    check(name, 64'(n), 64'(exp_cnt));
  endtask

  initial begin
    logic [W-1:0] hi_before;

    vecs[0] = '{1'b0, 32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{1'b1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'd0,          32'hFFFF_FFF9,  32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{1'b1, 32'h8000_0000,  32'd1,          32'hFFFF_FFFF, 32'h8000_0000};
    vecs[7] = '{1'b0, 32'h8000_0000,  32'd2,          32'h0000_0001, 32'h0000_0000};
    vecs[8] = '{1'b1, 32'd7,          32'hFFFF_FFFA,  32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vecs[9] = '{1'b0, 32'h1234_5678,  32'h0000_0010,  32'h0000_0001, 32'h2345_6780};

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);

    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      start_op(vecs[v].sgn, vecs[v].a, vecs[v].b, 1'b0, 1'b0, '0);
      wait_done($sformatf("vec%0d", v), W + 1);
      check($sformatf("vec%0d_hi", v), {32'd0, hi}, {32'd0, vecs[v].exp_hi});
      check($sformatf("vec%0d_lo", v), {32'd0, lo}, {32'd0, vecs[v].exp_lo});
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", v), {63'd0, done}, 64'd0);
    end

    // start and MTHI while busy are both ignored
    @(negedge clk);
    start_op(1'b0, 32'd3, 32'd5, 1'b0, 1'b0, '0);
    repeat (4) @(negedge clk);
    hi_before = hi;
    start = 1'b1; op_a = 32'd2; op_b = 32'd2; hi_we = 1'b1; wdata = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("busy_hi_we_ignored", {32'd0, hi}, {32'd0, hi_before});
    wait_done("busy_start", W + 1 - 5);
    check("busy_start_hi", {32'd0, hi}, 64'd0);
    check("busy_start_lo", {32'd0, lo}, 64'h0000_000F);
    count_stray_done("busy_start_single_done", 40, 0);
    check("busy_start_idle", {63'd0, busy}, 64'd0);

    // synchronous reset mid-run discards the operation
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    count_stray_done("midrst_no_done", 40, 0);
    start_op(1'b0, 32'd7, 32'd6, 1'b0, 1'b0, '0);
    wait_done("midrst_new", W + 1);
    check("midrst_new_hi", {32'd0, hi}, 64'd0);
    check("midrst_new_lo", {32'd0, lo}, 64'd42);

    // IDLE writes to HI/LO
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", {32'd0, hi}, 64'h1234);
    check("mthi_lo_kept", {32'd0, lo}, 64'd42);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_ABCD;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("both_we_hi", {32'd0, hi}, 64'hABCD);
    check("both_we_lo", {32'd0, lo}, 64'hABCD);

    // start wins over a same-edge MTLO
    start_op(1'b0, 32'd2, 32'd3, 1'b0, 1'b1, 32'h0000_9999);
    check("start_lo_we_dropped", {32'd0, lo}, 64'hABCD);
    wait_done("start_lo_we", W + 1);
    check("start_lo_we_hi", {32'd0, hi}, 64'd0);
    check("start_lo_we_lo", {32'd0, lo}, 64'd6);

    // back-to-back start issued in the done cycle
    start_op(1'b0, 32'd4, 32'd5, 1'b0, 1'b0, '0);
    wait_done("b2b", W + 1);
    check("b2b_hi", {32'd0, hi}, 64'd0);
    check("b2b_lo", {32'd0, lo}, 64'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
